load_store_unit: RTL and testbench

//  Memory-access stage directly downstream of the ALU. Consumes alucode and alu_result (effective address)

---
 rtl/load_store_unit_pkg.sv | 46 ++++
 rtl/load_store_unit_if.sv | 24 ++
 rtl/load_store_unit_lane_align.sv | 57 +++++
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 tb/tb_load_store_unit.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared opcode constants, enable levels, FSM encoding and opcode-class helpers
// used by the ALU, the decoder and the load/store stage.
package load_store_unit_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_SUB = 6'd1;
  localparam logic [5:0] ALU_AND = 6'd2;
  localparam logic [5:0] ALU_OR  = 6'd3;
  localparam logic [5:0] ALU_XOR = 6'd4;
  localparam logic [5:0] ALU_LB  = 6'd20;
  localparam logic [5:0] ALU_LH  = 6'd21;
  localparam logic [5:0] ALU_LW  = 6'd22;
  localparam logic [5:0] ALU_LBU = 6'd23;
  localparam logic [5:0] ALU_LHU = 6'd24;
  localparam logic [5:0] ALU_SB  = 6'd25;
  localparam logic [5:0] ALU_SH  = 6'd26;
  localparam logic [5:0] ALU_SW  = 6'd27;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic is_load(input logic [5:0] code);
    return code inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
  endfunction

  function automatic logic is_store(input logic [5:0] code);
    return code inside {ALU_SB, ALU_SH, ALU_SW};
  endfunction

  function automatic logic is_mem(input logic [5:0] code);
    return is_load(code) || is_store(code);
  endfunction

  function automatic logic is_misaligned(input logic [5:0] code, input logic [1:0] off);
    if (code inside {ALU_LH, ALU_LHU, ALU_SH}) return off[0];
    if (code inside {ALU_LW, ALU_SW})          return off != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Single-port word-wide data-memory handshake between the load/store stage
// (master) and the data memory (slave).
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and
// load-lane extraction with sign or zero extension.
module lsu_lane_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [5:0]      alucode,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);
  logic [XLEN-1:0] shifted;
  logic [7:0]      byte_val;
  logic [15:0]     half_val;

  always_comb begin
    be    = 4'b0000;
    wdata = '0;
    case (alucode)
      ALU_LB, ALU_LBU: be = 4'b0001 << byte_off;
      ALU_LH, ALU_LHU: be = 4'b0011 << {byte_off[1], 1'b0};
      ALU_LW:          be = 4'b1111;
      ALU_SB: begin
        be    = 4'b0001 << byte_off;
        wdata = {4{store_data[7:0]}};
      end
      ALU_SH: begin
        be    = 4'b0011 << {byte_off[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      ALU_SW: begin
        be    = 4'b1111;
        wdata = store_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted   = rdata >> {byte_off, 3'b000};
    byte_val  = shifted[7:0];
    half_val  = byte_off[1] ? rdata[31:16] : rdata[15:0];
    load_data = '0;
    case (alucode)
      ALU_LB:  load_data = {{24{byte_val[7]}}, byte_val};
      ALU_LBU: load_data = {24'd0, byte_val};
      ALU_LH:  load_data = {{16{half_val[15]}}, half_val};
      ALU_LHU: load_data = {16'd0, half_val};
      ALU_LW:  load_data = rdata;
      default: ;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one outstanding load/store, non-memory results pass through.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of truncating.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               alucode,
  input  logic [XLEN-1:0]          addr,
  input  logic [XLEN-1:0]          store_data,
  input  logic [4:0]               rd_in,
  load_store_unit_if.master        mem,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_data,
  output logic [4:0]               out_rd,
  output logic                     out_wb,
  output logic                     misaligned
);
  lsu_state_e        state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic              out_valid_q, out_valid_d, out_wb_q, out_wb_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;
  logic [4:0]        out_rd_q, out_rd_d, rd_q, rd_d;
  logic              misaligned_q, misaligned_d;
  logic [5:0]        code_q, code_d;
  logic [1:0]        off_q, off_d;

  logic              accept, trap;
  logic [5:0]        align_code;
  logic [1:0]        align_off;
  logic [3:0]        al_be;
  logic [XLEN-1:0]   al_wdata, al_load;

  assign accept = in_valid & in_ready_q;

  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    trap = is_mem(alucode) && is_misaligned(alucode, addr[1:0]);
`else
    trap = 1'b0;
`endif
  end

  // In IDLE the aligner steers the incoming request; afterwards it extracts from the latched one.
  assign align_code = (state_q == ST_IDLE) ? alucode    : code_q;
  assign align_off  = (state_q == ST_IDLE) ? addr[1:0]  : off_q;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .alucode    (align_code),
    .byte_off   (align_off),
    .store_data (store_data),
    .rdata      (mem.mem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_rd_q     <= 5'd0;
      out_wb_q     <= 1'b0;
      misaligned_q <= 1'b0;
      code_q       <= 6'd0;
      off_q        <= 2'b00;
      rd_q         <= 5'd0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_rd_q     <= out_rd_d;
      out_wb_q     <= out_wb_d;
      misaligned_q <= misaligned_d;
      code_q       <= code_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = (is_mem(alucode) && !trap) ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (mem.mem_ack) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_d   = (state_d == ST_IDLE);
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    out_rd_d     = out_rd_q;
    out_wb_d     = out_wb_q;
    misaligned_d = 1'b0;
    code_d       = code_q;
    off_d        = off_q;
    rd_d         = rd_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        code_d = alucode;
        off_d  = addr[1:0];
        rd_d   = rd_in;
        if (state_d == ST_ACCESS) begin
          mem_req_d   = 1'b1;
          mem_we_d    = is_store(alucode);
          mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
          mem_be_d    = al_be;
          mem_wdata_d = al_wdata;
        end else begin
          // Pass-through result, or the faulting address when trapping.
          out_valid_d  = 1'b1;
          out_data_d   = addr;
          out_rd_d     = rd_in;
          out_wb_d     = !trap;
          misaligned_d = trap;
        end
      end
      ST_ACCESS: if (mem.mem_ack) begin
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_be_d    = 4'b0000;
        mem_wdata_d = '0;
        out_valid_d = 1'b1;
        out_rd_d    = rd_q;
        out_wb_d    = !is_store(code_q);
        out_data_d  = is_store(code_q) ? '0 : al_load;
      end
      default: ;
    endcase
  end

  assign in_ready      = in_ready_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_rd        = out_rd_q;
  assign out_wb        = out_wb_q;
  assign misaligned    = misaligned_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: reset, pass-through, stores, loads with
// wait states, handshake behaviour and misaligned access handling.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  alucode = 6'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wb;
  logic        misaligned;
  int          vec = 0;
  int          err = 0;

  load_store_unit_if #(.ADDR_W(32), .XLEN(32)) mem_if ();

  load_store_unit #(.ADDR_W(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alucode(alucode), .addr(addr), .store_data(store_data), .rd_in(rd_in),
    .mem(mem_if.master), .out_valid(out_valid), .out_data(out_data),
    .out_rd(out_rd), .out_wb(out_wb), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge; returns in the cycle after acceptance.
  task automatic issue(input logic [5:0] c, input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd);
    alucode = c; addr = a; store_data = sd; rd_in = rd; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    vec++; if (mem_if.mem_req !== 1'b0 || mem_if.mem_be !== 4'b0000 || mem_if.mem_addr !== 32'd0) begin
      err++; $display("FAIL rst_mem: req %b be %b addr %h want 0", mem_if.mem_req, mem_if.mem_be, mem_if.mem_addr); end
    vec++; if (out_valid !== 1'b0 || out_data !== 32'd0 || out_wb !== 1'b0 || misaligned !== 1'b0) begin
      err++; $display("FAIL rst_out: valid %b data %h wb %b mis %b want 0", out_valid, out_data, out_wb, misaligned); end
    issue(ALU_LW, 32'h200, 32'd0, 5'd9);
    vec++; if (mem_if.mem_req !== 1'b1) begin err++; $display("FAIL rst_pre_req: got %b want 1", mem_if.mem_req); end
    rst = 1'b1;
    tick(); tick();
    vec++; if (mem_if.mem_req !== 1'b0 || out_valid !== 1'b0) begin
      err++; $display("FAIL rst_mid: req %b valid %b want 0 0", mem_if.mem_req, out_valid); end
    rst = 1'b0;
    mem_if.mem_ack = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        err++; $display("FAIL rst_after[%0d]: valid %b ready %b want 0 1", i, out_valid, in_ready); end
      tick();
    end
  endtask

  task automatic test_passthrough();
    issue(ALU_ADD, 32'h0000_1234, 32'd0, 5'd5);
    vec++; if (out_valid !== 1'b1 || out_data !== 32'h1234 || out_rd !== 5'd5 || out_wb !== 1'b1) begin
      err++; $display("FAIL pass_resp: valid %b data %h rd %0d wb %b want 1 1234 5 1", out_valid, out_data, out_rd, out_wb); end
    vec++; if (mem_if.mem_req !== 1'b0 || in_ready !== 1'b0) begin
      err++; $display("FAIL pass_busy: req %b ready %b want 0 0", mem_if.mem_req, in_ready); end
    tick();
    vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      err++; $display("FAIL pass_end: valid %b ready %b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_store();
    issue(ALU_SB, 32'h103, 32'hAABBCCDD, 5'd7);
    vec++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_we !== 1'b1 || mem_if.mem_addr !== 32'h100) begin
      err++; $display("FAIL sb_req: req %b we %b addr %h want 1 1 100", mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr); end
    vec++; if (mem_if.mem_be !== 4'b1000 || mem_if.mem_wdata !== 32'hDDDDDDDD) begin
      err++; $display("FAIL sb_lane: be %b wdata %h want 1000 dddddddd", mem_if.mem_be, mem_if.mem_wdata); end
    mem_if.mem_ack = 1'b1; tick(); mem_if.mem_ack = 1'b0;
    vec++; if (out_valid !== 1'b1 || out_wb !== 1'b0 || out_data !== 32'd0 || out_rd !== 5'd7 || mem_if.mem_req !== 1'b0) begin
      err++; $display("FAIL sb_resp: valid %b wb %b data %h rd %0d req %b want 1 0 0 7 0", out_valid, out_wb, out_data, out_rd, mem_if.mem_req); end
    tick();
    issue(ALU_SH, 32'h102, 32'h11223344, 5'd8);
    vec++; if (mem_if.mem_be !== 4'b1100 || mem_if.mem_wdata !== 32'h33443344 || mem_if.mem_addr !== 32'h100) begin
      err++; $display("FAIL sh_lane: be %b wdata %h addr %h want 1100 33443344 100", mem_if.mem_be, mem_if.mem_wdata, mem_if.mem_addr); end
    mem_if.mem_ack = 1'b1; tick(); mem_if.mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_loads();
    int req_cycles;
    issue(ALU_LB, 32'h101, 32'd0, 5'd10);
    vec++; if (mem_if.mem_we !== 1'b0 || mem_if.mem_be !== 4'b0010 || mem_if.mem_addr !== 32'h100) begin
      err++; $display("FAIL lb_req: we %b be %b addr %h want 0 0010 100", mem_if.mem_we, mem_if.mem_be, mem_if.mem_addr); end
    req_cycles = 0;
    for (int w = 0; w < 3; w++) begin
      if (mem_if.mem_req === 1'b1) req_cycles++;
      tick();
    end
    if (mem_if.mem_req === 1'b1) req_cycles++;
    mem_if.mem_rdata = 32'h0000_8000; mem_if.mem_ack = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0;
    vec++; if (req_cycles !== 4 || mem_if.mem_req !== 1'b0) begin
      err++; $display("FAIL lb_hold: held %0d cycles then req %b want 4 0", req_cycles, mem_if.mem_req); end
    vec++; if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FF80 || out_wb !== 1'b1 || out_rd !== 5'd10) begin
      err++; $display("FAIL lb_data: valid %b data %h wb %b rd %0d want 1 ffffff80 1 10", out_valid, out_data, out_wb, out_rd); end
    tick();
    issue(ALU_LBU, 32'h101, 32'd0, 5'd11);
    mem_if.mem_ack = 1'b1; tick(); mem_if.mem_ack = 1'b0;
    vec++; if (out_valid !== 1'b1 || out_data !== 32'h0000_0080) begin
      err++; $display("FAIL lbu_data: valid %b data %h want 1 00000080", out_valid, out_data); end
    tick();
    issue(ALU_LH, 32'h102, 32'd0, 5'd12);
    vec++; if (mem_if.mem_be !== 4'b1100) begin err++; $display("FAIL lh_be: got %b want 1100", mem_if.mem_be); end
    mem_if.mem_rdata = 32'h8001_0000; mem_if.mem_ack = 1'b1; tick(); mem_if.mem_ack = 1'b0;
    vec++; if (out_valid !== 1'b1 || out_data !== 32'hFFFF_8001) begin
      err++; $display("FAIL lh_data: valid %b data %h want 1 ffff8001", out_valid, out_data); end
    tick();
    issue(ALU_LHU, 32'h100, 32'd0, 5'd13);
    mem_if.mem_rdata = 32'h1234_F00D; mem_if.mem_ack = 1'b1; tick(); mem_if.mem_ack = 1'b0;
    vec++; if (out_data !== 32'h0000_F00D) begin err++; $display("FAIL lhu_data: got %h want 0000f00d", out_data); end
    tick();
  endtask

  task automatic test_handshake();
    int pulses;
    alucode = ALU_LW; addr = 32'h40; rd_in = 5'd3; in_valid = 1'b1;
    tick();
    vec++; if (in_ready !== 1'b0 || mem_if.mem_req !== 1'b1) begin
      err++; $display("FAIL hs_accept: ready %b req %b want 0 1", in_ready, mem_if.mem_req); end
    pulses = 0;
    tick();
    vec++; if (in_ready !== 1'b0) begin err++; $display("FAIL hs_wait: ready %b want 0", in_ready); end
    mem_if.mem_rdata = 32'hDEAD_BEEF; mem_if.mem_ack = 1'b1; tick(); mem_if.mem_ack = 1'b0;
    if (out_valid === 1'b1) pulses++;
    vec++; if (in_ready !== 1'b0 || out_data !== 32'hDEAD_BEEF) begin
      err++; $display("FAIL hs_resp: ready %b data %h want 0 deadbeef", in_ready, out_data); end
    tick();
    if (out_valid === 1'b1) pulses++;
    vec++; if (in_ready !== 1'b1 || pulses !== 1) begin
      err++; $display("FAIL hs_release: ready %b pulses %0d want 1 1", in_ready, pulses); end
    in_valid = 1'b0;
    mem_if.mem_ack = 1'b1; tick(); mem_if.mem_ack = 1'b0;
    vec++; if (out_valid !== 1'b0 || mem_if.mem_req !== 1'b0 || in_ready !== 1'b1) begin
      err++; $display("FAIL hs_spurious_ack: valid %b req %b ready %b want 0 0 1", out_valid, mem_if.mem_req, in_ready); end
    tick();
  endtask

  task automatic test_misalign();
    issue(ALU_LW, 32'h102, 32'd0, 5'd4);
`ifdef LSU_MISALIGN_TRAP_EN
    vec++; if (out_valid !== 1'b1 || misaligned !== 1'b1 || out_data !== 32'h102 || out_wb !== 1'b0) begin
      err++; $display("FAIL mis_trap: valid %b mis %b data %h wb %b want 1 1 102 0", out_valid, misaligned, out_data, out_wb); end
    vec++; if (mem_if.mem_req !== 1'b0) begin err++; $display("FAIL mis_noreq: req %b want 0", mem_if.mem_req); end
    tick();
`else
    vec++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h100 || mem_if.mem_be !== 4'b1111) begin
      err++; $display("FAIL mis_req: req %b addr %h be %b want 1 100 1111", mem_if.mem_req, mem_if.mem_addr, mem_if.mem_be); end
    mem_if.mem_rdata = 32'hCAFE_BABE; mem_if.mem_ack = 1'b1; tick(); mem_if.mem_ack = 1'b0;
    vec++; if (out_valid !== 1'b1 || out_data !== 32'hCAFE_BABE || misaligned !== 1'b0) begin
      err++; $display("FAIL mis_load: valid %b data %h mis %b want 1 cafebabe 0", out_valid, out_data, misaligned); end
    tick();
`endif
  endtask

  initial begin
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 32'd0;
    tick(); tick();
    rst = 1'b0;
    test_reset();
    test_passthrough();
    test_store();
    test_loads();
    test_handshake();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
